// File: rtl/fetch_stage.sv
// Instruction fetch front end: one outstanding imem request, a one-entry
// stall buffer for late responses, and the IF/ID pipeline register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [6:0]  id_opcode,
    output logic [2:0]  id_funct3,
    output logic [6:0]  id_funct7
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_pc_req;
    logic        r_discard;
    logic [31:0] r_hold_instr;
    logic [31:0] r_hold_pc;
    logic        r_id_valid;
    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc;

    logic        w_req;
    logic        w_accept;
    logic        w_resp;
    logic        w_deliver_wait;
    logic        w_deliver_hold;
    logic        w_capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FETCH: if (w_accept) w_state_nxt = S_WAIT;
            S_WAIT:  if (imem_rvalid) w_state_nxt = w_capture ? S_HOLD : S_FETCH;
            S_HOLD:  if (redirect_valid || !stall) w_state_nxt = S_FETCH;
            default: w_state_nxt = S_FETCH;
        endcase
    end

    // A response is usable only if it belongs to the current path.
    always_comb begin
        w_req          = (r_state == S_FETCH) && !stall && !redirect_valid;
        w_accept       = w_req && imem_ready;
        w_resp         = (r_state == S_WAIT) && imem_rvalid && !r_discard && !redirect_valid;
        w_deliver_wait = w_resp && !stall;
        w_capture      = w_resp && stall;
        w_deliver_hold = (r_state == S_HOLD) && !stall && !redirect_valid;
        imem_req       = w_req && rst_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= RESET_PC;
            r_discard    <= 1'b0;
            r_hold_instr <= '0;
            r_hold_pc    <= '0;
        end else begin
            if (redirect_valid) begin
                r_pc <= {redirect_pc[31:2], 2'b00};
            end else if (w_accept) begin
                r_pc <= r_pc + 32'd4;
            end
            if (r_state == S_WAIT) begin
                if (imem_rvalid) begin
                    r_discard <= 1'b0;
                end else if (redirect_valid) begin
                    r_discard <= 1'b1;
                end
            end
            if (w_capture) begin
                r_hold_instr <= imem_rdata;
                r_hold_pc    <= r_pc_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pc_req <= r_pc;
        end
    end

    // IF/ID register: flush beats delivery beats stall-hold beats bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id_valid <= 1'b0;
            r_id_instr <= NOP;
            r_id_pc    <= '0;
        end else if (flush) begin
            r_id_valid <= 1'b0;
            r_id_instr <= NOP;
            r_id_pc    <= '0;
        end else if (w_deliver_wait) begin
            r_id_valid <= 1'b1;
            r_id_instr <= imem_rdata;
            r_id_pc    <= r_pc_req;
        end else if (w_deliver_hold) begin
            r_id_valid <= 1'b1;
            r_id_instr <= r_hold_instr;
            r_id_pc    <= r_hold_pc;
        end else if (!stall) begin
            r_id_valid <= 1'b0;
            r_id_instr <= NOP;
            r_id_pc    <= '0;
        end
    end

    assign imem_addr = r_pc;
    assign id_valid  = r_id_valid;
    assign id_instr  = r_id_instr;
    assign id_pc     = r_id_pc;
    assign id_opcode = r_id_instr[6:0];
    assign id_funct3 = r_id_instr[14:12];
    assign id_funct7 = r_id_instr[31:25];

endmodule
